// File: rtl/udp_key_lookup.sv
// Duplicate-key lookup: fully associative table of recently seen UDP payload keys.
// Each accepted key is reported once with a hit/miss flag; misses are inserted round-robin.
module udp_key_lookup #(
   parameter int DEPTH = 16,
   parameter int KEY_W = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_axis_key_valid,
   input  logic [KEY_W-1:0]         s_axis_key,
   output logic                     s_axis_key_ready,
   output logic                     m_axis_key_udp_valid,
   output logic [KEY_W-1:0]         m_axis_key_udp,
   output logic                     m_axis_key_udp_result,
   input  logic                     m_axis_key_udp_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [31:0]              hit_count,
   output logic [31:0]              miss_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      OUT     = 2'd2
   } state_t;

   state_t               state_reg;
   state_t               state_next;
   logic [KEY_W-1:0]     key_reg;
   logic [KEY_W-1:0]     tag_reg [DEPTH];
   logic [DEPTH-1:0]     vld_reg;
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [DEPTH-1:0]     match;
   logic                 hit;
   logic                 accept;
   logic                 in_compare;
   logic                 ins_en;

   // Invalid entries are masked so a stale or zero tag can never match.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         assign match[gi] = vld_reg[gi] && (tag_reg[gi] == key_reg);
      end
   endgenerate

   assign hit        = |match;
   assign in_compare = (state_reg == COMPARE);
   assign ins_en     = in_compare && !hit && !flush;
   assign accept     = s_axis_key_valid && s_axis_key_ready;

   always_comb begin
      state_next       = state_reg;
      s_axis_key_ready = 1'b0;
      case (state_reg)
         IDLE: begin
            s_axis_key_ready = rst_n && !flush;
            if (s_axis_key_valid && rst_n && !flush) begin
               state_next = COMPARE;
            end
         end
         COMPARE: state_next = OUT;
         OUT: begin
            if (m_axis_key_udp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         key_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            key_reg <= s_axis_key;
         end
      end
   end

   // Output register: flush never disturbs a result that is already pending.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_axis_key_udp_valid  <= 1'b0;
         m_axis_key_udp        <= '0;
         m_axis_key_udp_result <= 1'b0;
      end else if (in_compare) begin
         m_axis_key_udp_valid  <= 1'b1;
         m_axis_key_udp        <= key_reg;
         m_axis_key_udp_result <= hit;
      end else if (state_reg == OUT && m_axis_key_udp_ready) begin
         m_axis_key_udp_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (ins_en) begin
         tag_reg[wr_ptr_reg] <= key_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         vld_reg    <= '0;
         wr_ptr_reg <= '0;
         occupancy  <= '0;
      end else if (ins_en) begin
         vld_reg[wr_ptr_reg] <= 1'b1;
         wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
         if (occupancy != OCC_W'(DEPTH)) begin
            occupancy <= occupancy + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (in_compare) begin
         if (hit) begin
            if (hit_count != 32'hFFFF_FFFF) begin
               hit_count <= hit_count + 32'd1;
            end
         end else begin
            if (miss_count != 32'hFFFF_FFFF) begin
               miss_count <= miss_count + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_udp_key_lookup.sv
// Randomized self-checking bench for udp_key_lookup against a FIFO-of-recent-keys model.
module tb_udp_key_lookup;

   localparam int DEPTH = 16;
   localparam int KEY_W = 64;
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid = 1'b0;
   logic [KEY_W-1:0]  s_key = '0;
   logic              s_ready;
   logic              m_valid;
   logic [KEY_W-1:0]  m_key;
   logic              m_result;
   logic              m_ready = 1'b0;
   logic              flush = 1'b0;
   logic [OCC_W-1:0]  occupancy;
   logic [31:0]       hit_count;
   logic [31:0]       miss_count;

   int n_checks = 0;
   int n_errors = 0;

   // Model: the table is the most recent DEPTH distinct missed keys, oldest first.
   logic [63:0]  mdl_q[$];
   int unsigned  mdl_hits = 0;
   int unsigned  mdl_misses = 0;
   logic [63:0]  key_pool [24];

   udp_key_lookup #(.DEPTH(DEPTH), .KEY_W(KEY_W)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .s_axis_key_valid      (s_valid),
      .s_axis_key            (s_key),
      .s_axis_key_ready      (s_ready),
      .m_axis_key_udp_valid  (m_valid),
      .m_axis_key_udp        (m_key),
      .m_axis_key_udp_result (m_result),
      .m_axis_key_udp_ready  (m_ready),
      .flush                 (flush),
      .occupancy             (occupancy),
      .hit_count             (hit_count),
      .miss_count            (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic mdl_clear();
      mdl_q.delete();
      mdl_hits   = 0;
      mdl_misses = 0;
   endtask

   task automatic mdl_lookup(input logic [63:0] k, output bit res);
      res = 1'b0;
      foreach (mdl_q[i]) if (mdl_q[i] == k) res = 1'b1;
      if (res) begin
         if (mdl_hits != 32'hFFFF_FFFF) mdl_hits++;
      end else begin
         if (mdl_misses != 32'hFFFF_FFFF) mdl_misses++;
         mdl_q.push_back(k);
         if (mdl_q.size() > DEPTH) void'(mdl_q.pop_front());
      end
   endtask

   task automatic check_stats(input string tag);
      check_val({tag, "_occ"},  64'(occupancy),  64'(mdl_q.size()));
      check_val({tag, "_hits"}, 64'(hit_count),  64'(mdl_hits));
      check_val({tag, "_miss"}, 64'(miss_count), 64'(mdl_misses));
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_key   = {$urandom, $urandom};
      m_ready = 1'b0;
      flush   = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         check_val("rst_s_ready", 64'(s_ready), 64'd0);
         check_val("rst_valid",   64'(m_valid), 64'd0);
         check_val("rst_key",     m_key, 64'd0);
         check_val("rst_result",  64'(m_result), 64'd0);
         check_val("rst_occ",     64'(occupancy), 64'd0);
         check_val("rst_hits",    64'(hit_count), 64'd0);
         check_val("rst_miss",    64'(miss_count), 64'd0);
      end
      rst_n = 1'b1;
      mdl_clear();
      #1;
      check_val("rst_release_ready", 64'(s_ready), 64'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      @(negedge clk);
      // The key held valid through reset is taken on the first cycle out of reset.
      check_val("rst_first_accept", 64'(s_ready), 64'd0);
      check_val("rst_first_cmp", 64'(m_valid), 64'd0);
      @(negedge clk);
      check_val("rst_first_out", 64'(m_valid), 64'd1);
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      // Reset again so the rest of the bench starts from an empty table.
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_stats("rst2");
   endtask

   // fl_mode: 0 = none, 1 = flush during COMPARE, 2 = flush during OUT (needs stall >= 1)
   task automatic do_key(input logic [63:0] k, input int stall, input int fl_mode);
      bit exp_res;
      int waitc;
      waitc   = 0;
      s_valid = 1'b1;
      s_key   = k;
      #1;
      while (!s_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!s_ready) begin
         check_val("accept_timeout", 64'(s_ready), 64'd1);
         s_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_key   = {$urandom, $urandom};
      mdl_lookup(k, exp_res);
      if (fl_mode == 1) flush = 1'b1;
      @(negedge clk);
      check_val("cmp_valid",   64'(m_valid), 64'd0);
      check_val("cmp_s_ready", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      if (flush) begin
         flush = 1'b0;
         mdl_clear();
      end
      @(negedge clk);
      check_val("out_valid",  64'(m_valid), 64'd1);
      check_val("out_key",    m_key, k);
      check_val("out_result", 64'(m_result), 64'(exp_res));
      check_stats("out");
      $display("key=%h result=%0d stall=%0d flush_mode=%0d occ=%0d", k, m_result, stall, fl_mode, occupancy);
      for (int c = 0; c < stall; c++) begin
         if (fl_mode == 2 && c == 0) flush = 1'b1;
         @(posedge clk);
         #1;
         if (flush) begin
            flush = 1'b0;
            mdl_clear();
         end
         @(negedge clk);
         check_val("hold_valid",   64'(m_valid), 64'd1);
         check_val("hold_key",     m_key, k);
         check_val("hold_result",  64'(m_result), 64'(exp_res));
         check_val("hold_s_ready", 64'(s_ready), 64'd0);
         check_stats("hold");
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      @(negedge clk);
      check_val("done_valid",   64'(m_valid), 64'd0);
      check_val("done_s_ready", 64'(s_ready), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (key_pool[i]) key_pool[i] = {$urandom, $urandom};
      do_reset();

      // basic miss then hit
      do_key(64'h0123_4567_89AB_CDEF, 0, 0);
      do_key(64'h0123_4567_89AB_CDEF, 0, 0);
      check_val("basic_occ",  64'(occupancy), 64'd1);
      check_val("basic_hits", 64'(hit_count), 64'd1);
      check_val("basic_miss", 64'(miss_count), 64'd1);

      // wrap and FIFO replacement
      do_reset();
      for (int i = 1; i <= 17; i++) do_key(64'(i), 0, 0);
      check_val("wrap_occ",  64'(occupancy), 64'd16);
      check_val("wrap_miss", 64'(miss_count), 64'd17);
      do_key(64'd1, 0, 0);
      do_key(64'd2, 0, 0);
      do_key(64'd3, 0, 0);

      // zero key against an empty table
      do_reset();
      do_key(64'd0, 0, 0);
      do_key(64'd0, 0, 0);

      // long backpressure, then flush in COMPARE and in OUT
      do_key(64'h5555, 10, 0);
      do_key(64'hAA, 0, 1);
      check_val("flush_cmp_occ", 64'(occupancy), 64'd0);
      do_key(64'hAA, 0, 0);
      do_key(64'hBB, 3, 2);

      // flush in IDLE blocks the key for that cycle and empties the table
      @(negedge clk);
      s_valid = 1'b1;
      s_key   = 64'hAA;
      flush   = 1'b1;
      #1;
      check_val("idle_flush_ready", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      flush   = 1'b0;
      s_valid = 1'b0;
      mdl_clear();
      @(negedge clk);
      check_val("idle_flush_no_accept", 64'(s_ready), 64'd1);
      check_val("idle_flush_valid", 64'(m_valid), 64'd0);
      check_stats("idle_flush");
      do_key(64'hAA, 0, 0);

      // randomized traffic over a small key pool
      for (int n = 0; n < 200; n++) begin
         int r;
         int st;
         int md;
         r  = $urandom_range(0, 19);
         st = $urandom_range(0, 3);
         md = (r == 0) ? 1 : (r == 1) ? 2 : 0;
         if (md == 2 && st == 0) st = 1;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_key(key_pool[$urandom_range(0, 23)], st, md);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
